// File: rtl/io_input_port_if.sv
// io_input_port_if
//   CPU-side register bus for io_input_port.
//   cs    : chip select from the I/O address decoder
//   addr  : register word index (CPU address bits [3:2])
//   rd    : read strobe, qualified by cs
//   we    : write strobe, qualified by cs
//   wdata : CPU store data
//   rdata : registered read data (returned by the peripheral)
`timescale 1ps/1ps
interface io_input_port_if;
    logic        cs;
    logic [1:0]  addr;
    logic        rd;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output cs, output addr, output rd, output we, output wdata, input rdata);
    modport slave  (input cs, input addr, input rd, input we, input wdata, output rdata);
endinterface

// File: rtl/io_input_port.sv
// io_input_port
//   Memory-mapped input peripheral: synchronizes the board switches,
//   synchronizes and debounces the active-low push keys, and records key
//   presses as sticky flags plus an 8-bit press counter.
//
//   Ports:
//     clock     : system clock, all state on the rising edge
//     resetn    : asynchronous active-low reset
//     sw[9:0]   : raw switch levels (asynchronous)
//     key[3:1]  : raw push keys, active-low (asynchronous)
//     bus       : CPU register bus (io_input_port_if.slave)
//     key_event : one-cycle pulse on any accepted key press
//     irq       : level interrupt, only when IO_IRQ_EN is defined
//
//   Register map (bus.addr):
//     0 SW     : {22'b0, sw_sync}                      (read only)
//     1 KEYLVL : {29'b0, ~stable}, 1 = key held        (read only)
//     2 FLAGS  : {29'b0, flags}, write-1-to-clear
//     3 COUNT  : {24'b0, press_cnt}, write loads the counter
//               with IO_IRQ_EN: {21'b0, mask, press_cnt}, write loads both
//
//   Optional macro: IO_IRQ_EN adds the irq output and a 3-bit mask register.
`timescale 1ps/1ps
module io_input_port #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [9:0]            sw,
    input  logic [3:1]            key,
    io_input_port_if.slave        bus,
`ifdef IO_IRQ_EN
    output logic                  irq,
`endif
    output logic                  key_event
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Two-flop synchronizers. Key flops idle at 1 (released).
    logic [9:0] sw_meta_q, sw_sync_q;
    logic [2:0] key_meta_q, key_sync_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            key_meta_q <= 3'b111;
            key_sync_q <= 3'b111;
        end else begin
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            key_meta_q <= key;
            key_sync_q <= key_meta_q;
        end
    end

    // Per-key debounce. Bit 0 of the vectors below corresponds to key[1].
    logic [2:0] stable_vec;
    logic [2:0] press_vec;

    for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             stable_q, stable_d;

        always_comb begin
            cnt_d    = cnt_q;
            stable_d = stable_q;
            if (key_sync_q[gi] == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LIMIT) begin
                // Enough consecutive differing cycles: accept the new level.
                stable_d = key_sync_q[gi];
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                cnt_q    <= '0;
                stable_q <= 1'b1;
            end else begin
                cnt_q    <= cnt_d;
                stable_q <= stable_d;
            end
        end

        assign stable_vec[gi] = stable_q;
        // Press = accepted 1->0 transition; releases are ignored here.
        assign press_vec[gi]  = stable_q & ~stable_d;
    end

    // Register file and bus.
    logic [2:0]  flags_q, flags_d;
    logic [7:0]  press_cnt_q, press_cnt_d;
    logic [31:0] rdata_q, rdata_d, rd_mux;
    logic        key_event_q;
    logic        wr_en, rd_en, any_press;
`ifdef IO_IRQ_EN
    logic [2:0]  mask_q, mask_d;
    logic        irq_q;
`endif

    assign wr_en     = bus.cs & bus.we;
    assign rd_en     = bus.cs & bus.rd;
    assign any_press = |press_vec;

    always_comb begin
        // W1C first, then OR in new presses so a same-cycle set wins.
        flags_d = flags_q;
        if (wr_en && bus.addr == 2'd2) begin
            flags_d = flags_d & ~bus.wdata[2:0];
        end
        flags_d = flags_d | press_vec;

        // A COUNT write takes priority over a same-cycle press.
        press_cnt_d = press_cnt_q;
        if (wr_en && bus.addr == 2'd3) begin
            press_cnt_d = bus.wdata[7:0];
        end else if (any_press) begin
            press_cnt_d = press_cnt_q + 8'd1;
        end

`ifdef IO_IRQ_EN
        mask_d = mask_q;
        if (wr_en && bus.addr == 2'd3) begin
            mask_d = bus.wdata[10:8];
        end
`endif

        // Read mux uses current (pre-write) state.
        rd_mux = '0;
        case (bus.addr)
            2'd0: rd_mux = {22'b0, sw_sync_q};
            2'd1: rd_mux = {29'b0, ~stable_vec};
            2'd2: rd_mux = {29'b0, flags_q};
`ifdef IO_IRQ_EN
            2'd3: rd_mux = {21'b0, mask_q, press_cnt_q};
`else
            2'd3: rd_mux = {24'b0, press_cnt_q};
`endif
            default: rd_mux = '0;
        endcase

        rdata_d = rd_en ? rd_mux : rdata_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            flags_q     <= '0;
            press_cnt_q <= '0;
            rdata_q     <= '0;
            key_event_q <= 1'b0;
`ifdef IO_IRQ_EN
            mask_q      <= '0;
            irq_q       <= 1'b0;
`endif
        end else begin
            flags_q     <= flags_d;
            press_cnt_q <= press_cnt_d;
            rdata_q     <= rdata_d;
            key_event_q <= any_press;
`ifdef IO_IRQ_EN
            mask_q      <= mask_d;
            // Registered from the flag register: trails a flag change by one cycle.
            irq_q       <= |(flags_q & mask_q);
`endif
        end
    end

    assign bus.rdata = rdata_q;
    assign key_event = key_event_q;
`ifdef IO_IRQ_EN
    assign irq       = irq_q;
`endif

endmodule

// File: tb/tb_io_input_port.sv
// tb_io_input_port
//   Directed bench for io_input_port. Reads push their expected value into a
//   scoreboard queue; a monitor pops and compares when read data is presented.
`timescale 1ps/1ps
module tb_io_input_port;

    logic       clock = 1'b0;
    logic       resetn;
    logic [9:0] sw;
    logic [3:1] key;
    logic       key_event;
`ifdef IO_IRQ_EN
    logic       irq;
`endif

    io_input_port_if bus();

    io_input_port #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .sw        (sw),
        .key       (key),
        .bus       (bus),
`ifdef IO_IRQ_EN
        .irq       (irq),
`endif
        .key_event (key_event)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_exp_t;
    rd_exp_t sb_q[$];

    int cyc = 0;
    int ev_cnt = 0;
    int last_ev_cyc = -1;
    logic rd_v = 1'b0;

    always @(posedge clock) begin
        cyc  <= cyc + 1;
        rd_v <= bus.cs & bus.rd;
    end

    // Read-data monitor.
    always @(negedge clock) begin
        if (rd_v) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got %h, required no read data", bus.rdata);
            end else begin
                rd_exp_t e;
                e = sb_q.pop_front();
                if (bus.rdata !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got %h, required %h", e.name, bus.rdata, e.exp);
                end else begin
                    $display("read %s: %h ok", e.name, bus.rdata);
                end
            end
        end
    end

    // Key-event monitor.
    always @(negedge clock) begin
        if (key_event === 1'b1) begin
            ev_cnt++;
            last_ev_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("check %s: %h ok", name, act);
        end
    endtask

    task automatic do_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        rd_exp_t e;
        @(negedge clock);
        bus.cs = 1'b1; bus.rd = 1'b1; bus.we = 1'b0; bus.addr = a;
        e.name = name; e.exp = exp;
        sb_q.push_back(e);
        @(negedge clock);
        bus.cs = 1'b0; bus.rd = 1'b0;
    endtask

    task automatic drive_write(input logic [1:0] a, input logic [31:0] d);
        bus.cs = 1'b1; bus.we = 1'b1; bus.rd = 1'b0; bus.addr = a; bus.wdata = d;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clock);
        drive_write(a, d);
        @(negedge clock);
        bus.cs = 1'b0; bus.we = 1'b0;
    endtask

    // Change keys, wait for debounce to settle.
    task automatic set_keys(input logic [3:1] k);
        @(negedge clock);
        key = k;
        repeat (10) @(negedge clock);
    endtask

    // Change keys and present a W1C of FLAGS on the cycle the press is accepted
    // (acceptance edge is the 6th rising edge after the change).
    task automatic press_with_clear(input logic [3:1] k, input logic [31:0] clr);
        @(negedge clock);
        key = k;
        repeat (5) @(negedge clock);
        drive_write(2'd2, clr);
        @(negedge clock);
        bus.cs = 1'b0; bus.we = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    int ev0;
    int c0;

    initial begin
        resetn = 1'b1;
        sw = 10'b1010101010;
        key = 3'b111;
        bus.cs = 1'b0; bus.rd = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = '0;

        #1 resetn = 1'b0;
        #5 resetn = 1'b1;
        #1;
        check("reset_rdata", bus.rdata, 32'h0);
        check("reset_key_event", {31'b0, key_event}, 32'h0);
`ifdef IO_IRQ_EN
        check("reset_irq", {31'b0, irq}, 32'h0);
`endif
        repeat (3) @(negedge clock);
        do_read(2'd0, 32'h2AA, "sw_after_reset");

        // Key2 press: event exactly once, 6 edges after the change.
        ev0 = ev_cnt;
        @(negedge clock);
        key = 3'b101;
        c0 = cyc;
        repeat (10) @(negedge clock);
        check("key2_event_count", ev_cnt - ev0, 1);
        check("key2_event_latency", last_ev_cyc - c0, 6);
        do_read(2'd2, 32'h2, "key2_flags");
        do_read(2'd1, 32'h2, "key2_keylvl");
        do_read(2'd3, 32'h1, "key2_count");

        // Glitch on key1 for 2 cycles.
        ev0 = ev_cnt;
        @(negedge clock);
        key = 3'b100;
        repeat (2) @(negedge clock);
        key = 3'b101;
        repeat (10) @(negedge clock);
        check("glitch_event_count", ev_cnt - ev0, 0);
        do_read(2'd2, 32'h2, "glitch_flags");
        do_read(2'd1, 32'h2, "glitch_keylvl");
        do_read(2'd3, 32'h1, "glitch_count");

        // Clear bit1 while key1 press sets bit0.
        ev0 = ev_cnt;
        press_with_clear(3'b100, 32'h2);
        check("coll1_event_count", ev_cnt - ev0, 1);
        do_read(2'd2, 32'h1, "coll1_flags");

        // Release key2, then clear bit1 on the cycle key2 press is accepted.
        set_keys(3'b110);
        press_with_clear(3'b100, 32'h2);
        do_read(2'd2, 32'h3, "coll2_flags");
        do_read(2'd3, 32'h3, "coll2_count");

        // Counter wrap.
        set_keys(3'b111);
        do_read(2'd1, 32'h0, "released_keylvl");
        do_write(2'd3, 32'hFF);
        do_read(2'd3, 32'hFF, "count_loaded");
        set_keys(3'b011);
        do_read(2'd3, 32'h0, "count_wrap");
        do_read(2'd1, 32'h4, "key3_keylvl");
        do_read(2'd2, 32'h7, "key3_flags");

        // Switch update.
        @(negedge clock);
        sw = 10'b0101010101;
        repeat (3) @(negedge clock);
        do_read(2'd0, 32'h155, "sw_inverted");

        // Writes to read-only registers are ignored.
        do_write(2'd1, 32'hFFFF_FFFF);
        do_write(2'd0, 32'hFFFF_FFFF);
        do_read(2'd1, 32'h4, "keylvl_ro");
        do_read(2'd0, 32'h155, "sw_ro");

        // Simultaneous read and write of COUNT: read returns the old value.
        @(negedge clock);
        drive_write(2'd3, 32'h5);
        bus.rd = 1'b1;
        begin
            rd_exp_t e;
            e.name = "rdwr_old"; e.exp = 32'h0;
            sb_q.push_back(e);
        end
        @(negedge clock);
        bus.cs = 1'b0; bus.we = 1'b0; bus.rd = 1'b0;
        do_read(2'd3, 32'h5, "rdwr_new");

`ifdef IO_IRQ_EN
        set_keys(3'b111);
        do_write(2'd2, 32'h7);
        do_write(2'd3, 32'h400);
        do_read(2'd3, 32'h400, "irq_mask_count");
        check("irq_idle", {31'b0, irq}, 32'h0);
        set_keys(3'b110);
        check("irq_key1_masked", {31'b0, irq}, 32'h0);
        do_read(2'd2, 32'h1, "irq_key1_flags");
        @(negedge clock);
        key = 3'b010;
        repeat (6) @(negedge clock);
        check("irq_before", {31'b0, irq}, 32'h0);
        @(negedge clock);
        check("irq_asserted", {31'b0, irq}, 32'h1);
        @(negedge clock);
        drive_write(2'd2, 32'h4);
        @(negedge clock);
        bus.cs = 1'b0; bus.we = 1'b0;
        @(negedge clock);
        check("irq_cleared", {31'b0, irq}, 32'h0);
`endif

        repeat (3) @(negedge clock);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
